// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD scan display: digit count,
// segment lookup table and the packed {dp, bcd} display word.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] bcd;
  } disp_word_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment pattern, full hex range.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/bcd_scan_display.sv
// Latches the CPU-written BCD word and scans it onto a 4-digit common-anode
// display, swapping values only at frame boundaries. Optional LEADING_ZERO_BLANK_EN.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        bcd_we,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pending
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    idx_q, idx_d;
  disp_word_t    pend_q, pend_d;
  disp_word_t    disp_q, disp_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          boundary;
  logic          lit;
  logic          digit_blank;
  logic [3:0]    cur_nibble;
  logic [6:0]    dec_seg;

  assign tick       = (prescaler_q == PRESC_LAST);
  assign boundary   = tick && (idx_q == 2'd3);
  assign lit        = (prescaler_q >= BLANK_END);
  assign cur_nibble = disp_q.bcd[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed only when it and every digit to its left are zero
  always_comb begin
    digit_blank = 1'b0;
    case (idx_q)
      2'd3:    digit_blank = (disp_q.bcd[15:12] == 4'h0);
      2'd2:    digit_blank = (disp_q.bcd[15:8] == 8'h00);
      2'd1:    digit_blank = (disp_q.bcd[15:4] == 12'h000);
      default: digit_blank = 1'b0;
    endcase
  end
`else
  assign digit_blank = 1'b0;
`endif

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    idx_d       = tick ? idx_q + 2'd1 : idx_q;

    pend_d    = pend_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (bcd_we) begin
      pend_d    = {dp_in, bcd_in};
      pending_d = 1'b1;
    end
    // A write landing on the boundary itself bypasses the pending register
    if (boundary) begin
      if (bcd_we) begin
        disp_d    = {dp_in, bcd_in};
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
    end

    frame_done_d = boundary;
    an_d         = 4'b1111;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = digit_blank ? SEG_BLANK : dec_seg;
      dp_d  = ~disp_q.dp[idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q  <= '0;
      idx_q        <= 2'd0;
      pend_q       <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display with SCAN_DIV=4, BLANK_CYCLES=1.
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_bcd_scan_display;

  logic        clk;
  logic        reset;
  logic [15:0] bcdIn;
  logic [3:0]  dpIn;
  logic        bcdWe;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frameDone;
  logic        pending;

  int numCompared;
  int numMismatched;

  bcd_scan_display #(
    .SCAN_DIV     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcdIn),
    .dp_in      (dpIn),
    .bcd_we     (bcdWe),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frameDone),
    .pending    (pending)
  );

  // 10 ns clock; all sampling and driving happens on the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a one-cycle write strobe starting at the current falling edge
  task automatic applyStimulus(input logic [15:0] value, input logic [3:0] dots);
    bcdIn = value;
    dpIn  = dots;
    bcdWe = 1'b1;
    step(1);
    bcdWe = 1'b0;
  endtask

  // Bounded wait for the next frame_done pulse
  task automatic waitFrame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (frameDone === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  // Called right after frame_done is seen: checks the blank slot start and all four lit digits
  task automatic showFrame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dpLow);
    logic [3:0] expAn [4];
    logic [6:0] expSeg [4];
    expAn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    expSeg = '{s0, s1, s2, s3};
    step(1);
    checkOutput({tag, "_blank_an"},  {28'd0, an},  {28'd0, 4'b1111});
    checkOutput({tag, "_blank_seg"}, {25'd0, seg}, {25'd0, 7'h7F});
    checkOutput({tag, "_blank_dp"},  {31'd0, dp},  32'd1);
    for (int k = 0; k < 4; k++) begin
      step(k == 0 ? 1 : 4);
      checkOutput($sformatf("%s_an%0d", tag, k),  {28'd0, an},  {28'd0, expAn[k]});
      checkOutput($sformatf("%s_seg%0d", tag, k), {25'd0, seg}, {25'd0, expSeg[k]});
      checkOutput($sformatf("%s_dp%0d", tag, k),  {31'd0, dp},  {31'd0, dpLow[k]});
    end
  endtask

  initial begin
    logic [3:0] scanAn [16];
    numCompared   = 0;
    numMismatched = 0;
    reset = 1'b1;
    bcdIn = 16'h0000;
    dpIn  = 4'h0;
    bcdWe = 1'b0;

    step(2);
    checkOutput("rst_an",      {28'd0, an},        {28'd0, 4'b1111});
    checkOutput("rst_seg",     {25'd0, seg},       {25'd0, 7'h7F});
    checkOutput("rst_dp",      {31'd0, dp},        32'd1);
    checkOutput("rst_frame",   {31'd0, frameDone}, 32'd0);
    checkOutput("rst_pending", {31'd0, pending},   32'd0);

    // Test 1: idle scan straight out of reset, edge by edge
    reset = 1'b0;
    scanAn = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101,
               4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111};
    for (int k = 0; k < 16; k++) begin
      step(1);
      checkOutput($sformatf("scan_an_%0d", k), {28'd0, an}, {28'd0, scanAn[k]});
      checkOutput($sformatf("scan_seg_%0d", k), {25'd0, seg},
                  (k % 4 == 0) ? 32'h7F : 32'h40);
      checkOutput($sformatf("scan_fd_%0d", k), {31'd0, frameDone}, (k == 15) ? 32'd1 : 32'd0);
    end
    waitFrame();
    checkOutput("frame_period_fd", {31'd0, frameDone}, 32'd1);

    // Test 2: mid-frame write held pending until the boundary
    step(2);
    applyStimulus(16'h1A8F, 4'b0000);
    checkOutput("t2_pending_set", {31'd0, pending}, 32'd1);
    waitFrame();
    checkOutput("t2_pending_clr", {31'd0, pending}, 32'd0);
    showFrame("t2", 7'h0E, 7'h00, 7'h08, 7'h79, 4'b1111);

    // Test 3: last write in a frame wins
    waitFrame();
    step(2);
    applyStimulus(16'h1111, 4'b0000);
    step(2);
    applyStimulus(16'h2222, 4'b0000);
    checkOutput("t3_pending", {31'd0, pending}, 32'd1);
    waitFrame();
    showFrame("t3", 7'h24, 7'h24, 7'h24, 7'h24, 4'b1111);

    // Test 4: write coincident with the boundary tick goes straight to display
    step(1);
    applyStimulus(16'h0005, 4'b0000);
    checkOutput("t4_fd", {31'd0, frameDone}, 32'd1);
    checkOutput("t4_pending", {31'd0, pending}, 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    showFrame("t4", 7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
`else
    showFrame("t4", 7'h12, 7'h40, 7'h40, 7'h40, 4'b1111);
`endif
    checkOutput("t4_pending_after", {31'd0, pending}, 32'd0);

    // Test 5: decimal point only on digit 2
    waitFrame();
    step(3);
    applyStimulus(16'h8888, 4'b0100);
    waitFrame();
    showFrame("t5", 7'h00, 7'h00, 7'h00, 7'h00, 4'b1011);

    // Test 6: leading-zero handling, then reset mid-slot discards pending value
    waitFrame();
    step(2);
    applyStimulus(16'h0030, 4'b0000);
    waitFrame();
`ifdef LEADING_ZERO_BLANK_EN
    showFrame("t6", 7'h40, 7'h30, 7'h7F, 7'h7F, 4'b1111);
`else
    showFrame("t6", 7'h40, 7'h30, 7'h40, 7'h40, 4'b1111);
`endif
    applyStimulus(16'h1234, 4'b1111);
    checkOutput("t6_pending_pre", {31'd0, pending}, 32'd1);
    checkOutput("t6_an_pre", {28'd0, an}, {28'd0, 4'b0111});
    #1 reset = 1'b1;
    #1;
    checkOutput("t6_rst_an",      {28'd0, an},      {28'd0, 4'b1111});
    checkOutput("t6_rst_seg",     {25'd0, seg},     {25'd0, 7'h7F});
    checkOutput("t6_rst_dp",      {31'd0, dp},      32'd1);
    checkOutput("t6_rst_pending", {31'd0, pending}, 32'd0);
    step(2);
    reset = 1'b0;
    waitFrame();
    checkOutput("t6_post_pending", {31'd0, pending}, 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    showFrame("t6post", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
`else
    showFrame("t6post", 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
